// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives a combinational instruction memory, and
// buffers one fetched word toward decode. Optional misaligned-target trap: FETCH_MISALIGN_CHECK_EN.
module if_fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          IMEM_SIZE = 128,
  parameter logic [31:0] PC_STEP   = 32'd4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic [31:0] instr_addr,
  input  logic [31:0] instr,
  input  logic        id_ready,
  output logic        id_valid,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc,
  output logic [31:0] id_pc4,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  output logic        halted,
  output logic [31:0] fetch_count
`ifdef FETCH_MISALIGN_CHECK_EN
  ,
  output logic        misalign
`endif
);

  localparam logic [31:0] LAST_PC = 32'(IMEM_SIZE - 4);

  typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;

  state_t      state, state_nxt;
  logic [31:0] pc, pc_nxt;
  logic        valid_nxt, halted_nxt;
  logic        at_end, fire, redir, bad_target;

`ifdef FETCH_MISALIGN_CHECK_EN
  logic        misalign_nxt;
  assign bad_target = (redirect_target[1:0] != 2'b00);
`else
  assign bad_target = 1'b0;
`endif

  assign instr_addr = pc;
  assign at_end     = (pc > LAST_PC);
  assign redir      = redirect_valid && (state != IDLE);
  // A pending redirect suppresses the fetch so the wrong-path word never enters the buffer.
  assign fire       = (state == RUN) && !redirect_valid && !at_end && (!id_valid || id_ready);

  always_comb begin
    state_nxt  = state;
    pc_nxt     = pc;
    valid_nxt  = id_valid;
    halted_nxt = halted;
`ifdef FETCH_MISALIGN_CHECK_EN
    misalign_nxt = misalign;
`endif

    case (state)
      IDLE: begin
        if (start)          state_nxt = RUN;
        if (redirect_valid) pc_nxt    = redirect_target;
      end
      RUN: begin
        if (at_end && !redirect_valid) begin
          state_nxt  = HALT;
          halted_nxt = 1'b1;
        end
      end
      default: ;
    endcase

    if (fire) begin
      pc_nxt    = pc + PC_STEP;
      valid_nxt = 1'b1;
    end else if (id_valid && id_ready) begin
      valid_nxt = 1'b0;
    end

    if (redir) begin
      pc_nxt     = redirect_target;
      valid_nxt  = 1'b0;
      state_nxt  = bad_target ? HALT : RUN;
      halted_nxt = bad_target;
`ifdef FETCH_MISALIGN_CHECK_EN
      misalign_nxt = bad_target;
`endif
    end
  end

  // Control: state, PC, halt flag, counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      pc          <= RESET_PC;
      halted      <= 1'b0;
      fetch_count <= 32'd0;
`ifdef FETCH_MISALIGN_CHECK_EN
      misalign    <= 1'b0;
`endif
    end else begin
      state  <= state_nxt;
      pc     <= pc_nxt;
      halted <= halted_nxt;
      if (fire) fetch_count <= fetch_count + 32'd1;
`ifdef FETCH_MISALIGN_CHECK_EN
      misalign <= misalign_nxt;
`endif
    end
  end

  // IF/ID boundary: the buffered word only changes on an accepted fetch
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      id_valid <= 1'b0;
      id_instr <= 32'd0;
      id_pc    <= 32'd0;
      id_pc4   <= 32'd0;
    end else begin
      id_valid <= valid_nxt;
      if (fire) begin
        id_instr <= instr;
        id_pc    <= pc;
        id_pc4   <= pc + PC_STEP;
      end
    end
  end

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed, table-driven bench for if_fetch_stage with a combinational memory model.
module tb_if_fetch_stage;

  logic        clk, rst_n, start, id_ready, id_valid, redirect_valid, halted;
  logic [31:0] instr_addr, instr, id_instr, id_pc, id_pc4, redirect_target, fetch_count;
`ifdef FETCH_MISALIGN_CHECK_EN
  logic        misalign;
`endif

  int total = 0;
  int passed = 0;

  if_fetch_stage #(.RESET_PC(32'h0), .IMEM_SIZE(128), .PC_STEP(32'd4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .instr_addr(instr_addr), .instr(instr),
    .id_ready(id_ready), .id_valid(id_valid), .id_instr(id_instr), .id_pc(id_pc),
    .id_pc4(id_pc4), .redirect_valid(redirect_valid), .redirect_target(redirect_target),
    .halted(halted), .fetch_count(fetch_count)
`ifdef FETCH_MISALIGN_CHECK_EN
    , .misalign(misalign)
`endif
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'hABCD_0000 ^ a;
  endfunction

  assign instr = mem_word(instr_addr);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic s, input logic r, input logic rv, input logic [31:0] t);
    start = s; id_ready = r; redirect_valid = rv; redirect_target = t;
  endtask

  typedef struct {
    logic        start;
    logic        ready;
    logic        redir;
    logic [31:0] target;
    logic        e_valid;
    logic [31:0] e_pc;
    logic [31:0] e_fc;
    logic [31:0] e_addr;
    logic        e_halted;
  } vec_t;

  function automatic vec_t mk(input logic s, input logic r, input logic rv, input logic [31:0] t,
                              input logic ev, input logic [31:0] ep, input logic [31:0] efc,
                              input logic [31:0] ea, input logic eh);
    vec_t v;
    v.start = s; v.ready = r; v.redir = rv; v.target = t;
    v.e_valid = ev; v.e_pc = ep; v.e_fc = efc; v.e_addr = ea; v.e_halted = eh;
    return v;
  endfunction

  vec_t vecs[19];

  initial begin
    vecs[0]  = mk(1, 1, 0, 0,     0, 32'h00, 0, 32'h00, 0);  // start -> RUN, no word yet
    vecs[1]  = mk(0, 1, 0, 0,     1, 32'h00, 1, 32'h04, 0);
    vecs[2]  = mk(0, 1, 0, 0,     1, 32'h04, 2, 32'h08, 0);
    vecs[3]  = mk(0, 1, 0, 0,     1, 32'h08, 3, 32'h0C, 0);
    vecs[4]  = mk(0, 0, 0, 0,     1, 32'h08, 3, 32'h0C, 0);  // stall x3
    vecs[5]  = mk(0, 0, 0, 0,     1, 32'h08, 3, 32'h0C, 0);
    vecs[6]  = mk(0, 0, 0, 0,     1, 32'h08, 3, 32'h0C, 0);
    vecs[7]  = mk(0, 1, 0, 0,     1, 32'h0C, 4, 32'h10, 0);
    vecs[8]  = mk(0, 1, 1, 32'h20,0, 32'h0C, 4, 32'h20, 0);  // redirect beats fetch at 0x10
    vecs[9]  = mk(0, 1, 0, 0,     1, 32'h20, 5, 32'h24, 0);
    vecs[10] = mk(0, 1, 1, 32'h78,0, 32'h20, 5, 32'h78, 0);
    vecs[11] = mk(0, 1, 0, 0,     1, 32'h78, 6, 32'h7C, 0);
    vecs[12] = mk(0, 1, 0, 0,     1, 32'h7C, 7, 32'h80, 0);  // last word
    vecs[13] = mk(0, 0, 0, 0,     1, 32'h7C, 7, 32'h80, 1);  // HALT, word still buffered
    vecs[14] = mk(0, 1, 0, 0,     0, 32'h7C, 7, 32'h80, 1);  // drained
    vecs[15] = mk(1, 1, 0, 0,     0, 32'h7C, 7, 32'h80, 1);  // start ignored in HALT
    vecs[16] = mk(0, 1, 1, 32'h00,0, 32'h7C, 7, 32'h00, 0);  // redirect out of HALT
    vecs[17] = mk(0, 1, 0, 0,     1, 32'h00, 8, 32'h04, 0);
    vecs[18] = mk(0, 1, 0, 0,     1, 32'h04, 9, 32'h08, 0);

    rst_n = 1'b0;
    drive(0, 0, 0, 0);
    #3;
    chk("reset id_valid", {31'd0, id_valid}, 32'd0);
    chk("reset instr_addr", instr_addr, 32'h0);
    chk("reset id_instr", id_instr, 32'h0);
    chk("reset id_pc", id_pc, 32'h0);
    chk("reset id_pc4", id_pc4, 32'h0);
    chk("reset halted", {31'd0, halted}, 32'd0);
    chk("reset fetch_count", fetch_count, 32'd0);
    #9 rst_n = 1'b1;

    for (int i = 0; i < 19; i++) begin
      drive(vecs[i].start, vecs[i].ready, vecs[i].redir, vecs[i].target);
      step();
      chk($sformatf("v%0d id_valid", i), {31'd0, id_valid}, {31'd0, vecs[i].e_valid});
      chk($sformatf("v%0d id_pc", i), id_pc, vecs[i].e_pc);
      chk($sformatf("v%0d fetch_count", i), fetch_count, vecs[i].e_fc);
      chk($sformatf("v%0d instr_addr", i), instr_addr, vecs[i].e_addr);
      chk($sformatf("v%0d halted", i), {31'd0, halted}, {31'd0, vecs[i].e_halted});
      if (vecs[i].e_valid) begin
        chk($sformatf("v%0d id_instr", i), id_instr, mem_word(vecs[i].e_pc));
        chk($sformatf("v%0d id_pc4", i), id_pc4, vecs[i].e_pc + 32'd4);
      end
    end

    // Misaligned redirect from RUN (pc=0x08, buffer holds 0x04, fc=9)
    drive(0, 1, 1, 32'h06);
    step();
    chk("mis id_valid", {31'd0, id_valid}, 32'd0);
    chk("mis instr_addr", instr_addr, 32'h06);
`ifdef FETCH_MISALIGN_CHECK_EN
    chk("mis misalign", {31'd0, misalign}, 32'd1);
    chk("mis halted", {31'd0, halted}, 32'd1);
    drive(0, 1, 0, 0);
    step();
    chk("mis hold id_valid", {31'd0, id_valid}, 32'd0);
    chk("mis hold fetch_count", fetch_count, 32'd9);
    chk("mis hold misalign", {31'd0, misalign}, 32'd1);
    drive(0, 1, 1, 32'h08);
    step();
    chk("realign misalign", {31'd0, misalign}, 32'd0);
    chk("realign halted", {31'd0, halted}, 32'd0);
    drive(0, 1, 0, 0);
    step();
    chk("realign id_valid", {31'd0, id_valid}, 32'd1);
    chk("realign id_pc", id_pc, 32'h08);
    chk("realign fetch_count", fetch_count, 32'd10);
`else
    chk("mis halted", {31'd0, halted}, 32'd0);
    drive(0, 1, 0, 0);
    step();
    chk("mis id_valid fetched", {31'd0, id_valid}, 32'd1);
    chk("mis id_pc", id_pc, 32'h06);
    chk("mis id_instr", id_instr, mem_word(32'h06));
    chk("mis id_pc4", id_pc4, 32'h0A);
    chk("mis fetch_count", fetch_count, 32'd10);
`endif

    // Asynchronous reset mid-cycle with a word buffered
    step();
    chk("pre-reset id_valid", {31'd0, id_valid}, 32'd1);
    chk("pre-reset fetch_count", fetch_count, 32'd11);
    #2 rst_n = 1'b0;
    #1;
    chk("async id_valid", {31'd0, id_valid}, 32'd0);
    chk("async instr_addr", instr_addr, 32'h0);
    chk("async fetch_count", fetch_count, 32'd0);
    chk("async halted", {31'd0, halted}, 32'd0);
    #3 rst_n = 1'b1;
    for (int i = 0; i < 3; i++) step();
    chk("idle id_valid", {31'd0, id_valid}, 32'd0);
    chk("idle instr_addr", instr_addr, 32'h0);
    chk("idle fetch_count", fetch_count, 32'd0);

    // Redirect in IDLE moves the PC only
    drive(0, 1, 1, 32'h10);
    step();
    chk("idle redir instr_addr", instr_addr, 32'h10);
    drive(0, 1, 0, 0);
    step();
    chk("idle redir id_valid", {31'd0, id_valid}, 32'd0);
    chk("idle redir fetch_count", fetch_count, 32'd0);
    drive(1, 1, 0, 0);
    step();
    chk("restart id_valid", {31'd0, id_valid}, 32'd0);
    drive(0, 1, 0, 0);
    step();
    chk("restart id_valid2", {31'd0, id_valid}, 32'd1);
    chk("restart id_pc", id_pc, 32'h10);
    chk("restart id_instr", id_instr, mem_word(32'h10));
    chk("restart fetch_count", fetch_count, 32'd1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
